// File: rtl/rca_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_pkg
// Description : Shared types and constants for the sequential ripple-carry
//               adder controller: FSM state encoding and slice width.
// Revision    : 1.0  initial release
// ============================================================================
package rca_seq_pkg;

  // Width of one arithmetic slice handled per RUN cycle
  localparam int SLICE_W = 4;

  // Controller states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : rca_seq_pkg
`default_nettype wire

// File: rtl/rca_4bit.sv
`default_nettype none
// ============================================================================
// Module      : rca_4bit
// Description : One SLICE_W-bit ripple-carry adder slice (a + b + ci).
// Revision    : 1.0  initial release
// ============================================================================
module rca_4bit
  import rca_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  // Bit-serial ripple of the carry through the slice
  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule : rca_4bit
`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_ctrl
// Description : Sequential adder. Captures operands, adds one 4-bit slice per
//               RUN cycle through a single rca_4bit, then presents sum, carry
//               out and signed overflow with a valid/ready handshake.
//               Optional macro RCA_SEQ_SUB_EN adds a 'sub' input selecting
//               a - b (a + ~b + 1, cin ignored).
// Revision    : 1.0  initial release
// ============================================================================
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = SLICE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;       // holds the effective (possibly inverted) b
  logic [W-1:0]       acc_q, acc_d;   // working sum filled slice by slice
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [W-1:0]       b_eff;
  logic               cin_eff;
  logic [SLICE_W-1:0] add_a, add_b, add_s;
  logic               add_co;

`ifdef RCA_SEQ_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign add_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign add_b = b_q[idx_q*SLICE_W +: SLICE_W];

  rca_4bit u_rca_4bit (
    .a  (add_a),
    .b  (add_b),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = cin_eff;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q*SLICE_W +: SLICE_W] = add_s;
        carry_d = add_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle publishes the result; outputs then stay frozen
        if (!out_valid_q) begin
          sum_d       = acc_q;
          cout_d      = carry_q;
          ovf_d       = (a_q[W-1] == b_q[W-1]) && (acc_q[W-1] != a_q[W-1]);
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule : rca_seq_ctrl
`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_seq_ctrl
// Description : Directed self-checking bench for rca_seq_ctrl (NIBBLES=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_rca_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
`ifdef RCA_SEQ_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef RCA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request; returns #1 after the accepting edge E
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // operands must already be captured; scramble the inputs
    a = ~av; b = ~bv; cin = ~cv;
  endtask

  // Called #1 after edge E; checks latency and result, optionally handshakes
  task automatic finish_op(input string tag, input logic [15:0] es, input logic ec,
                           input logic eo, input bit hs);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready_run"}, in_ready, 0);
    repeat (4) @(posedge clk);
    #1 chk({tag, "_valid_e4"}, out_valid, 0);
    @(posedge clk);
    #1 chk({tag, "_valid_e5"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    if (hs) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_after_hs"}, out_valid, 0);
      chk({tag, "_in_ready_after_hs"}, in_ready, 1);
      chk({tag, "_sum_hold"}, sum, es);
    end
  endtask

  initial begin
    bit saw_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Carry ripples through every slice
    start_op(16'hFFFF, 16'h0001, 1'b0);
    finish_op("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    // Positive overflow
    start_op(16'h7FFF, 16'h0001, 1'b0);
    finish_op("povf", 16'h8000, 1'b0, 1'b1, 1'b1);
    // Carry-in used
    start_op(16'h1234, 16'h1111, 1'b1);
    finish_op("cin", 16'h2346, 1'b0, 1'b0, 1'b1);
    // Negative overflow
    start_op(16'h8000, 16'h8000, 1'b0);
    finish_op("novf", 16'h0000, 1'b1, 1'b1, 1'b1);

    // Back-pressure in DONE with a competing request held
    start_op(16'h00FF, 16'h0F01, 1'b0);
    finish_op("bp", 16'h1000, 1'b0, 1'b0, 1'b0);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, 16'h1000);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_hs_in_ready", in_ready, 1);
    chk("bp_hs_busy", busy, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    finish_op("bp_next", 16'h0002, 1'b0, 1'b0, 1'b1);

    // Reset in the second RUN cycle aborts the operation
    start_op(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("arst_no_valid", saw_valid, 0);
    start_op(16'hA5A5, 16'h5A5A, 1'b1);
    finish_op("arst_next", 16'h0000, 1'b1, 1'b0, 1'b1);

`ifdef RCA_SEQ_SUB_EN
    sub = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b0);
    finish_op("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    sub = 1'b1;
    start_op(16'h0007, 16'h0005, 1'b1);
    finish_op("sub_pos", 16'h0002, 1'b1, 1'b0, 1'b1);
    sub = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rca_seq_ctrl
`default_nettype wire
